// File: rtl/sap_pc_pkg.sv
// sap_pc_pkg: shared op encoding, default sizes and strobe-priority resolver for the SAP program counter
package sap_pc_pkg;
   localparam int PC_WIDTH_DEF = 16;
   localparam int PC_DEPTH_DEF = 4;
   typedef enum logic [2:0] {PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET} pc_op_e;
   function automatic pc_op_e pc_resolve(input logic call, input logic ret, input logic lp, input logic cp);
      return call ? PC_CALL : ret ? PC_RET : lp ? PC_LOAD : cp ? PC_INC : PC_HOLD;
   endfunction
endpackage

// File: rtl/pc_call_ret_stack.sv
// ret_stack: return-address LIFO with pointer and EMPTY/FULL decodes, falling-edge clocked
module ret_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             CLK_BAR,
   input  logic             CLR_BAR,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             EMPTY,
   output logic             FULL
);
   localparam int PW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;
   assign EMPTY = ptr == '0;
   assign FULL  = ptr == PW'(DEPTH);
   // push writes the slot at the pointer; pop only moves the pointer, leaving the old entry in place
   always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
      if (!CLR_BAR) begin
         ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !FULL) begin
         for (int i = 0; i < DEPTH; i++) if (PW'(i) == ptr) mem[i] <= din;
         ptr <= ptr + PW'(1);
      end else if (pop && !EMPTY) begin
         ptr <= ptr - PW'(1);
      end
   end
   // top of stack is the entry just below the pointer
   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) if (PW'(i + 1) == ptr) top = mem[i];
   end
endmodule

// File: rtl/pc_call.sv
// pc_call: SAP program counter with count, jump, CALL/RET and gated bus output (tri-state bus with PC_BUS_TRISTATE_EN)
module pc_call
   import sap_pc_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH_DEF,
   parameter int DEPTH = PC_DEPTH_DEF
) (
   input  logic             CLK_BAR,
   input  logic             CLR_BAR,
   input  logic             CP,
   input  logic             LP,
   input  logic             CALL,
   input  logic             RET,
   input  logic             EP,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
`ifdef PC_BUS_TRISTATE_EN
   output tri   [WIDTH-1:0] BUS_OUT,
`else
   output logic [WIDTH-1:0] BUS_OUT,
`endif
   output logic             EMPTY,
   output logic             FULL,
   output logic             ERR
);
   pc_op_e           op;
   logic             push, pop;
   logic [WIDTH-1:0] top, q_inc;
   assign op    = pc_resolve(CALL, RET, LP, CP);
   assign q_inc = Q + WIDTH'(1);
   assign push  = op == PC_CALL && !FULL;
   assign pop   = op == PC_RET && !EMPTY;
`ifdef PC_BUS_TRISTATE_EN
   assign BUS_OUT = EP ? Q : 'z;
`else
   assign BUS_OUT = EP ? Q : '0;
`endif
   ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
      .CLK_BAR(CLK_BAR),
      .CLR_BAR(CLR_BAR),
      .push   (push),
      .pop    (pop),
      .din    (q_inc),
      .top    (top),
      .EMPTY  (EMPTY),
      .FULL   (FULL)
   );
   // PC and sticky error update; a rejected CALL/RET leaves Q alone and only sets ERR
   always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
      if (!CLR_BAR) begin
         Q   <= '0;
         ERR <= 1'b0;
      end else begin
         Q   <= push ? D : pop ? top : op == PC_LOAD ? D : op == PC_INC ? q_inc : Q;
         ERR <= ERR | (op == PC_CALL && FULL) | (op == PC_RET && EMPTY);
      end
   end
endmodule

// File: tb/tb_pc_call.sv
// tb_pc_call: scoreboard bench for pc_call (WIDTH=8, DEPTH=2) against a queue-based reference model
module tb_pc_call;
   localparam int W = 8;
   localparam int N = 2;
   typedef struct {
      logic [W-1:0] q;
      logic         e, f, r;
      logic [W-1:0] bus;
   } exp_t;
   logic CLK_BAR = 1'b1, CLR_BAR = 1'b1;
   logic CP = 0, LP = 0, CALL = 0, RET = 0, EP = 0;
   logic [W-1:0] D = '0;
   logic [W-1:0] Q, BUS_OUT;
   logic EMPTY, FULL, ERR;
   int total = 0, bad = 0;
   exp_t exp_q[$];
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_stk[$];
   logic m_err = 0;

   pc_call #(.WIDTH(W), .DEPTH(N)) dut (
      .CLK_BAR(CLK_BAR), .CLR_BAR(CLR_BAR), .CP(CP), .LP(LP), .CALL(CALL), .RET(RET),
      .EP(EP), .D(D), .Q(Q), .BUS_OUT(BUS_OUT), .EMPTY(EMPTY), .FULL(FULL), .ERR(ERR)
   );

   always #5 CLK_BAR = ~CLK_BAR;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
      end
   endtask

   function automatic logic [W-1:0] exp_bus(input logic ep, input logic [W-1:0] q);
`ifdef PC_BUS_TRISTATE_EN
      return ep ? q : 'z;
`else
      return ep ? q : '0;
`endif
   endfunction

   function automatic exp_t snap();
      exp_t x;
      x.q = m_q; x.e = m_stk.size() == 0; x.f = m_stk.size() == N; x.r = m_err;
      x.bus = exp_bus(EP, m_q);
      return x;
   endfunction

   task automatic model_step();
      if (CALL) begin
         if (m_stk.size() == N) m_err = 1;
         else begin m_stk.push_back(m_q + 8'd1); m_q = D; end
      end else if (RET) begin
         if (m_stk.size() == 0) m_err = 1;
         else m_q = m_stk.pop_back();
      end else if (LP) m_q = D;
      else if (CP) m_q = m_q + 8'd1;
   endtask

   task automatic cyc(input logic call, input logic ret, input logic lp, input logic cp,
                      input logic ep, input logic [W-1:0] d);
      @(posedge CLK_BAR);
      CLR_BAR = 1; CALL = call; RET = ret; LP = lp; CP = cp; EP = ep; D = d;
      model_step();
      exp_q.push_back(snap());
   endtask

   task automatic rst_pulse();
      @(posedge CLK_BAR);
      CALL = 1; RET = 0; LP = 0; CP = 0; D = 8'h5A;
      #2 CLR_BAR = 0;
      #1;
      chk("async_q", Q, '0);
      chk("async_empty", {7'd0, EMPTY}, 8'd1);
      chk("async_full_err", {6'd0, FULL, ERR}, 8'd0);
      m_q = '0; m_stk.delete(); m_err = 0;
      exp_q.push_back(snap());
   endtask

   always @(negedge CLK_BAR) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         chk("q", Q, x.q);
         chk("empty", {7'd0, EMPTY}, {7'd0, x.e});
         chk("full", {7'd0, FULL}, {7'd0, x.f});
         chk("err", {7'd0, ERR}, {7'd0, x.r});
         chk("bus", BUS_OUT, x.bus);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_pulse();
      repeat (3) cyc(0, 0, 0, 1, 0, 8'h00);
      cyc(0, 0, 1, 0, 0, 8'hFF);
      cyc(0, 0, 0, 1, 0, 8'h00);
      cyc(0, 0, 1, 0, 0, 8'h10);
      cyc(0, 0, 1, 1, 0, 8'h40);
      cyc(1, 1, 0, 0, 0, 8'h80);
      cyc(0, 1, 0, 0, 0, 8'h00);
      rst_pulse();
      cyc(0, 0, 1, 0, 0, 8'h05);
      cyc(1, 0, 0, 0, 0, 8'h20);
      cyc(1, 0, 0, 0, 0, 8'h30);
      cyc(0, 1, 0, 0, 0, 8'h00);
      cyc(0, 1, 0, 0, 0, 8'h00);
      cyc(1, 0, 0, 0, 0, 8'h20);
      cyc(1, 0, 0, 0, 0, 8'h30);
      cyc(1, 0, 1, 1, 0, 8'h99);
      repeat (5) cyc(0, 0, 0, 0, 0, 8'h00);
      rst_pulse();
      cyc(0, 1, 0, 0, 0, 8'h00);
      rst_pulse();
      cyc(0, 0, 1, 0, 0, 8'h3C);
      cyc(0, 0, 0, 0, 1, 8'h00);
      cyc(0, 0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) rst_pulse();
         else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom));
      end
      @(negedge CLK_BAR);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
